// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit type codes, head field positions and
// the injector FSM state type. Reused by the router wrapper and NI receiver.
package noc_pkg;

  localparam int FLIT_W = 35;

  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;

  localparam int FT_MSB = 34;
  localparam int FT_LSB = 33;

  localparam int HEAD_DST_X_LSB = 6;
  localparam int HEAD_DST_Y_LSB = 4;
  localparam int HEAD_SRC_X_LSB = 2;
  localparam int HEAD_SRC_Y_LSB = 0;

  typedef enum logic {
    INJ_IDLE = 1'b0,
    INJ_DATA = 1'b1
  } inj_state_t;

  // Head payload holds only the four coordinates; every other bit stays zero.
  function automatic logic [FLIT_W-1:0] make_head(input logic [1:0] dst_x,
                                                  input logic [1:0] dst_y,
                                                  input logic [1:0] src_x,
                                                  input logic [1:0] src_y);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FT_MSB:FT_LSB]           = FT_HEAD;
    f[HEAD_DST_X_LSB +: 2]     = dst_x;
    f[HEAD_DST_Y_LSB +: 2]     = dst_y;
    f[HEAD_SRC_X_LSB +: 2]     = src_x;
    f[HEAD_SRC_Y_LSB +: 2]     = src_y;
    return f;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Per-VC credit counter: starts full, counts down on emit, up on OACK, saturates
// at BUF_DEPTH and flags a sticky overflow when an OACK arrives while full.
module noc_credit_counter #(
  parameter int BUF_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             RST_,
  input  logic                             dec,
  input  logic                             inc,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   cnt,
  output logic                             nonzero,
  output logic                             ovf
);

  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      cnt <= FULL;
      ovf <= 1'b0;
    end else begin
      case ({dec, inc})
        2'b10: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        2'b01: begin
          if (cnt == FULL) ovf <= 1'b1;
          else             cnt <= cnt + CW'(1);
        end
        default: ;  // idle, or emit and return cancel out
      endcase
    end
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/noc_local_injector.sv
// Local-port packet injector: head flit then one flit per core word, credit-based
// flow control per VC. Optional NOC_INJ_STATS_EN adds pkt_cnt / stall_cnt outputs.
//
// Core handshake: a word transfers on a cycle where pkt_valid && pkt_ready are both
// high; pkt_ready is only ever high in DATA and never depends on pkt_valid.
module noc_local_injector
  import noc_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int NUM_VC    = 2
) (
  input  logic                             clk,
  input  logic                             RST_,
  input  logic [1:0]                       MY_XPOS,
  input  logic [1:0]                       MY_YPOS,
  input  logic                             pkt_valid,
  output logic                             pkt_ready,
  input  logic [31:0]                      pkt_data,
  input  logic                             pkt_last,
  input  logic                             pkt_vc,
  input  logic [1:0]                       pkt_dst_x,
  input  logic [1:0]                       pkt_dst_y,
  output logic [FLIT_W-1:0]                IDATA,
  output logic                             IVALID,
  output logic                             IVCH,
  input  logic [1:0]                       OACK,
  input  logic [1:0]                       ORDY,
  output logic                             cred_err,
  output inj_state_t                       dbg_state,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   dbg_cred0,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   dbg_cred1
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [15:0]                      pkt_cnt,
  output logic [15:0]                      stall_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH+1);

  inj_state_t        state_q, state_d;
  logic              vc_q;
  logic              emit;
  logic              emit_vc;
  logic              ready;
  logic [FLIT_W-1:0] flit_d;

  logic [NUM_VC-1:0] dec;
  logic [NUM_VC-1:0] cred_nz;
  logic [NUM_VC-1:0] cred_ovf;
  logic [NUM_VC-1:0] can_send;
  logic [CW-1:0]     cred [NUM_VC];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign dec[v] = emit && (int'(emit_vc) == v);

    noc_credit_counter #(
      .BUF_DEPTH (BUF_DEPTH)
    ) u_cred (
      .clk     (clk),
      .RST_    (RST_),
      .dec     (dec[v]),
      .inc     (OACK[v]),
      .cnt     (cred[v]),
      .nonzero (cred_nz[v]),
      .ovf     (cred_ovf[v])
    );
  end

  // Registered credit view: a counter hitting zero blocks the very next decision.
  assign can_send = cred_nz & ORDY;

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    emit_vc = vc_q;
    ready   = 1'b0;
    flit_d  = '0;
    case (state_q)
      INJ_IDLE: begin
        if (pkt_valid && can_send[pkt_vc]) begin
          emit    = 1'b1;
          emit_vc = pkt_vc;
          flit_d  = make_head(pkt_dst_x, pkt_dst_y, MY_XPOS, MY_YPOS);
          state_d = INJ_DATA;
        end
      end
      INJ_DATA: begin
        ready = can_send[vc_q];
        if (pkt_valid && ready) begin
          emit   = 1'b1;
          flit_d = {(pkt_last ? FT_TAIL : FT_BODY), 1'b0, pkt_data};
          if (pkt_last) state_d = INJ_IDLE;
        end
      end
      default: state_d = INJ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      state_q <= INJ_IDLE;
      vc_q    <= 1'b0;
      IVALID  <= 1'b0;
      IDATA   <= '0;
      IVCH    <= 1'b0;
    end else begin
      state_q <= state_d;
      IVALID  <= emit;
      if (emit && (state_q == INJ_IDLE)) vc_q <= pkt_vc;
      if (emit) begin
        IDATA <= flit_d;
        IVCH  <= emit_vc;
      end
    end
  end

`ifdef NOC_INJ_STATS_EN
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (emit && (flit_d[FT_MSB:FT_LSB] == FT_TAIL)) pkt_cnt <= pkt_cnt + 16'd1;
      if (pkt_valid && !emit)                         stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  assign pkt_ready = ready;
  assign cred_err  = |cred_ovf;
  assign dbg_state = state_q;
  assign dbg_cred0 = cred[0];
  assign dbg_cred1 = cred[1];

endmodule

// File: tb/tb_noc_local_injector.sv
// Self-checking bench for noc_local_injector: packet-level reference model with
// an expected-flit queue, directed credit/reset scenarios and randomized traffic.
module tb_noc_local_injector;
  import noc_pkg::*;

  localparam int BUF_DEPTH = 4;
  localparam int CW = $clog2(BUF_DEPTH+1);

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic RST_ = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        MY_XPOS = 2'd1;
  logic [1:0]        MY_YPOS = 2'd0;
  logic              pkt_valid = 1'b0;
  logic              pkt_ready;
  logic [31:0]       pkt_data = '0;
  logic              pkt_last = 1'b0;
  logic              pkt_vc = 1'b0;
  logic [1:0]        pkt_dst_x = '0;
  logic [1:0]        pkt_dst_y = '0;
  logic [FLIT_W-1:0] IDATA;
  logic              IVALID;
  logic              IVCH;
  logic [1:0]        OACK = '0;
  logic [1:0]        ORDY = 2'b11;
  logic              cred_err;
  inj_state_t        dbg_state;
  logic [CW-1:0]     dbg_cred0;
  logic [CW-1:0]     dbg_cred1;

  noc_local_injector #(.BUF_DEPTH(BUF_DEPTH), .NUM_VC(2)) dut (
    .clk       (clk),
    .RST_      (RST_),
    .MY_XPOS   (MY_XPOS),
    .MY_YPOS   (MY_YPOS),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .pkt_last  (pkt_last),
    .pkt_vc    (pkt_vc),
    .pkt_dst_x (pkt_dst_x),
    .pkt_dst_y (pkt_dst_y),
    .IDATA     (IDATA),
    .IVALID    (IVALID),
    .IVCH      (IVCH),
    .OACK      (OACK),
    .ORDY      (ORDY),
    .cred_err  (cred_err),
    .dbg_state (dbg_state),
    .dbg_cred0 (dbg_cred0),
    .dbg_cred1 (dbg_cred1)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [35:0] exp_q[$];      // {vc, flit} in emission order
  int          m_cred[2];
  bit          m_in_pkt, m_vc, m_err, m_ready, m_accept, obs_ready;
  int          cyc = 0;
  int          pkt_flits, first_cyc, last_cyc;
  logic [35:0] first_flit, got;

  task automatic model_reset();
    m_cred   = '{BUF_DEPTH, BUF_DEPTH};
    m_in_pkt = 0;
    m_vc     = 0;
    m_err    = 0;
    exp_q.delete();
  endtask

  // One clock: apply OACK/ORDY, predict from packet rules, advance to next negedge.
  task automatic tick(input logic [1:0] oack, input logic [1:0] ordy);
    bit          emit, ev;
    logic [34:0] f;
    logic [32:0] head_pl;
    OACK = oack;
    ORDY = ordy;
    #1;
    obs_ready = pkt_ready;
    emit = 0; ev = 0; f = '0; m_accept = 0;
    m_ready = m_in_pkt && (m_cred[m_vc] > 0) && ordy[m_vc];
    if (!m_in_pkt && pkt_valid && (m_cred[pkt_vc] > 0) && ordy[pkt_vc]) begin
      head_pl = 33'(pkt_dst_x) * 64 + 33'(pkt_dst_y) * 16 + 33'(MY_XPOS) * 4 + 33'(MY_YPOS);
      emit = 1; ev = pkt_vc; f = {2'b01, head_pl};
      m_in_pkt = 1; m_vc = pkt_vc;
    end else if (m_in_pkt && pkt_valid && m_ready) begin
      emit = 1; ev = m_vc; m_accept = 1;
      f = {(pkt_last ? 2'b10 : 2'b00), 1'b0, pkt_data};
      if (pkt_last) m_in_pkt = 0;
    end
    for (int v = 0; v < 2; v++) begin
      bit d, i;
      d = emit && (int'(ev) == v);
      i = oack[v];
      if (d && !i) m_cred[v]--;
      else if (i && !d) begin
        if (m_cred[v] == BUF_DEPTH) m_err = 1;
        else m_cred[v]++;
      end
    end
    if (emit) exp_q.push_back({ev, f});
    @(negedge clk);
    OACK = '0;
    cyc++;
  endtask

  // ---------------- driver: one packet with per-cycle checking ----------------
  task automatic send_pkt(input bit vc, input logic [1:0] dx, input logic [1:0] dy,
                          input int n, input bit rnd);
    logic [31:0] words[8];
    logic [1:0]  oack, ordy;
    int          i = 0;
    int          guard = 0;
    for (int k = 0; k < 8; k++) words[k] = $urandom;
    pkt_vc = vc; pkt_dst_x = dx; pkt_dst_y = dy; pkt_valid = 1;
    pkt_flits = 0;
    while (i < n && guard < 400) begin
      pkt_data = words[i];
      pkt_last = (i == n - 1);
      oack = '0;
      ordy = 2'b11;
      if (rnd) begin
        for (int v = 0; v < 2; v++)
          if (m_cred[v] < BUF_DEPTH) oack[v] = 1'($urandom_range(0, 1));
        ordy = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
      end
      tick(oack, ordy);
      n_checks++;
      if (obs_ready !== m_ready) begin
        n_fail++; $display("FAIL pkt_ready: got %b exp %b (cyc %0d)", obs_ready, m_ready, cyc);
      end
      n_checks++;
      if (IVALID !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL ivalid: got %b exp %b (cyc %0d)", IVALID, exp_q.size() != 0, cyc);
      end
      if (IVALID === 1'b1 && exp_q.size() != 0) begin
        got = {IVCH, IDATA};
        n_checks++;
        if (got !== exp_q[0]) begin
          n_fail++; $display("FAIL flit: got %h exp %h", got, exp_q[0]);
        end
        if (pkt_flits == 0) begin first_flit = got; first_cyc = cyc; end
        last_cyc = cyc;
        pkt_flits++;
        void'(exp_q.pop_front());
      end
      n_checks++;
      if ({dbg_cred1, dbg_cred0, cred_err} !== {CW'(m_cred[1]), CW'(m_cred[0]), m_err}) begin
        n_fail++;
        $display("FAIL credits: got c1=%0d c0=%0d err=%b exp c1=%0d c0=%0d err=%b",
                 dbg_cred1, dbg_cred0, cred_err, m_cred[1], m_cred[0], m_err);
      end
      if (m_accept) i++;
      guard++;
    end
    pkt_valid = 0; pkt_last = 0;
    n_checks++;
    if (i != n) begin
      n_fail++; $display("FAIL pkt_timeout: got %0d words exp %0d", i, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_ = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({IVALID, IVCH, pkt_ready, cred_err} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ctl: got %b exp 0000", {IVALID, IVCH, pkt_ready, cred_err});
    end
    n_checks++;
    if (IDATA !== '0) begin n_fail++; $display("FAIL rst_idata: got %h exp 0", IDATA); end
    n_checks++;
    if (dbg_cred0 !== CW'(4) || dbg_cred1 !== CW'(4)) begin
      n_fail++; $display("FAIL rst_cred: got %0d/%0d exp 4/4", dbg_cred0, dbg_cred1);
    end
    n_checks++;
    if (dbg_state !== INJ_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    RST_ = 1;
    model_reset();
    tick(2'b00, 2'b11);
    tick(2'b00, 2'b11);
    n_checks++;
    if (IVALID !== 1'b0 || dbg_cred0 !== CW'(4)) begin
      n_fail++; $display("FAIL idle: got ivalid=%b cred0=%0d exp 0/4", IVALID, dbg_cred0);
    end
  endtask

  task automatic test_single_packet();
    send_pkt(1'b1, 2'd2, 2'd3, 3, 1'b0);
    n_checks++;
    if (first_flit !== {1'b1, 2'b01, 33'h0_0000_00B4}) begin
      n_fail++; $display("FAIL head_value: got %h exp %h", first_flit, {1'b1, 2'b01, 33'h0B4});
    end
    n_checks++;
    if (pkt_flits != 4 || (last_cyc - first_cyc) != 3) begin
      n_fail++; $display("FAIL b2b: got %0d flits over %0d cyc exp 4 over 3", pkt_flits, last_cyc - first_cyc);
    end
    for (int k = 0; k < 4; k++) tick(2'b10, 2'b11);
  endtask

  task automatic test_credit_stall();
    logic [31:0] w[6];
    int          i = 0;
    int          flits = 0;
    for (int k = 0; k < 6; k++) w[k] = $urandom;
    pkt_vc = 0; pkt_dst_x = 2'd3; pkt_dst_y = 2'd1; pkt_valid = 1;
    for (int c = 0; c < 8; c++) begin
      pkt_data = w[i]; pkt_last = (i == 5);
      tick(2'b00, 2'b11);
      if (m_accept) i++;
      if (IVALID === 1'b1) begin
        flits++;
        n_checks++;
        if ({IVCH, IDATA} !== exp_q[0]) begin
          n_fail++; $display("FAIL stall_flit: got %h exp %h", {IVCH, IDATA}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (flits != 4 || pkt_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_count: got %0d flits ready=%b exp 4 flits ready=0", flits, pkt_ready);
    end
    for (int k = 0; k < 3; k++) begin
      pkt_data = w[i]; pkt_last = (i == 5);
      tick(2'b01, 2'b11);
      n_checks++;
      if (IVALID !== 1'b0) begin n_fail++; $display("FAIL release_early: got %b exp 0", IVALID); end
      tick(2'b00, 2'b11);
      if (m_accept) i++;
      n_checks++;
      if (IVALID !== 1'b1 || exp_q.size() == 0 || {IVCH, IDATA} !== exp_q[0]) begin
        n_fail++; $display("FAIL release_flit: got v=%b %h exp v=1", IVALID, {IVCH, IDATA});
      end
      exp_q.delete();
    end
    pkt_valid = 0;
    n_checks++;
    if (i != 6 || dbg_state !== INJ_IDLE) begin
      n_fail++; $display("FAIL stall_done: got %0d words state=%0d exp 6 words state=0", i, dbg_state);
    end
    for (int k = 0; k < 4; k++) tick(2'b01, 2'b11);
    n_checks++;
    if (dbg_cred0 !== CW'(4)) begin n_fail++; $display("FAIL stall_refill: got %0d exp 4", dbg_cred0); end
  endtask

  task automatic test_same_cycle();
    send_pkt(1'b0, 2'd1, 2'd1, 3, 1'b0);   // drains VC0 to zero
    pkt_vc = 0; pkt_valid = 1; pkt_last = 1; pkt_data = $urandom;
    tick(2'b01, 2'b11);
    n_checks++;
    if (IVALID !== 1'b0 || dbg_cred0 !== CW'(1)) begin
      n_fail++; $display("FAIL zero_oack: got v=%b cred=%0d exp v=0 cred=1", IVALID, dbg_cred0);
    end
    tick(2'b00, 2'b11);
    n_checks++;
    if (IVALID !== 1'b1 || {IVCH, IDATA} !== exp_q[0] || dbg_cred0 !== CW'(0)) begin
      n_fail++; $display("FAIL zero_send: got v=%b %h cred=%0d exp v=1 %h cred=0", IVALID, {IVCH, IDATA}, dbg_cred0, exp_q[0]);
    end
    void'(exp_q.pop_front());
    tick(2'b01, 2'b11);
    tick(2'b00, 2'b11);
    n_checks++;
    if (IVALID !== 1'b1 || exp_q.size() == 0 || {IVCH, IDATA} !== exp_q[0]) begin
      n_fail++; $display("FAIL zero_tail: got v=%b %h", IVALID, {IVCH, IDATA});
    end
    exp_q.delete();
    pkt_valid = 0;
    tick(2'b01, 2'b11);
    tick(2'b01, 2'b11);
    pkt_valid = 1; pkt_last = 0; pkt_dst_x = 2'd0; pkt_dst_y = 2'd2;
    tick(2'b01, 2'b11);
    n_checks++;
    if (IVALID !== 1'b1 || dbg_cred0 !== CW'(2) || {IVCH, IDATA} !== exp_q[0]) begin
      n_fail++; $display("FAIL net_zero: got v=%b cred=%0d exp v=1 cred=2", IVALID, dbg_cred0);
    end
    void'(exp_q.pop_front());
    pkt_last = 1;
    tick(2'b00, 2'b11);
    n_checks++;
    if (IVALID !== 1'b1 || dbg_cred0 !== CW'(1) || {IVCH, IDATA} !== exp_q[0]) begin
      n_fail++; $display("FAIL net_tail: got v=%b cred=%0d exp v=1 cred=1", IVALID, dbg_cred0);
    end
    exp_q.delete();
    pkt_valid = 0;
    for (int k = 0; k < 3; k++) tick(2'b01, 2'b11);
  endtask

  task automatic test_ordy_err();
    pkt_vc = 0; pkt_valid = 1; pkt_last = 1; pkt_data = $urandom;
    for (int k = 0; k < 4; k++) begin
      tick(2'b00, 2'b10);
      n_checks++;
      if (IVALID !== 1'b0 || dbg_cred0 !== CW'(4)) begin
        n_fail++; $display("FAIL ordy_block: got v=%b cred=%0d exp v=0 cred=4", IVALID, dbg_cred0);
      end
    end
    tick(2'b10, 2'b10);
    n_checks++;
    if (cred_err !== 1'b1 || dbg_cred1 !== CW'(4) || m_err != 1) begin
      n_fail++; $display("FAIL cred_err_set: got err=%b cred1=%0d exp err=1 cred1=4", cred_err, dbg_cred1);
    end
    tick(2'b00, 2'b11);
    tick(2'b00, 2'b11);
    n_checks++;
    if (cred_err !== 1'b1) begin n_fail++; $display("FAIL cred_err_sticky: got %b exp 1", cred_err); end
    n_checks++;
    if (IVALID !== 1'b1 || exp_q.size() != 2 || {IVCH, IDATA} !== exp_q[1]) begin
      n_fail++; $display("FAIL ordy_resume: got v=%b %h exp v=1 tail", IVALID, {IVCH, IDATA});
    end
    exp_q.delete();
    pkt_valid = 0;
    tick(2'b01, 2'b11);
    tick(2'b01, 2'b11);
  endtask

  task automatic test_random();
    for (int p = 0; p < 10; p++)
      send_pkt(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               int'($urandom_range(1, 5)), 1'b1);
    for (int k = 0; k < 12; k++)
      tick({1'(m_cred[1] < BUF_DEPTH), 1'(m_cred[0] < BUF_DEPTH)}, 2'b11);
    n_checks++;
    if (dbg_cred0 !== CW'(4) || dbg_cred1 !== CW'(4) || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: got %0d/%0d q=%0d exp 4/4 q=0", dbg_cred0, dbg_cred1, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    pkt_vc = 1; pkt_dst_x = 2'd2; pkt_dst_y = 2'd0; pkt_valid = 1; pkt_last = 0; pkt_data = $urandom;
    tick(2'b00, 2'b11);
    tick(2'b00, 2'b11);
    n_checks++;
    if (IVALID !== 1'b1 || dbg_cred1 !== CW'(2)) begin
      n_fail++; $display("FAIL mid_pre: got v=%b cred1=%0d exp v=1 cred1=2", IVALID, dbg_cred1);
    end
    RST_ = 0;
    #1;
    n_checks++;
    if ({IVALID, IVCH, cred_err} !== 3'b000 || IDATA !== '0) begin
      n_fail++; $display("FAIL async_clear: got v=%b vc=%b err=%b d=%h exp all 0", IVALID, IVCH, cred_err, IDATA);
    end
    n_checks++;
    if (dbg_cred1 !== CW'(4) || dbg_state !== INJ_IDLE) begin
      n_fail++; $display("FAIL async_state: got cred1=%0d state=%0d exp 4/0", dbg_cred1, dbg_state);
    end
    pkt_valid = 0;
    @(negedge clk);
    @(negedge clk);
    RST_ = 1;
    model_reset();
    send_pkt(1'b0, 2'd3, 2'd1, 2, 1'b0);
    n_checks++;
    if (first_flit[34:33] !== FT_HEAD || dbg_cred0 !== CW'(1)) begin
      n_fail++; $display("FAIL post_reset: got type=%b cred0=%0d exp 01/1", first_flit[34:33], dbg_cred0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_packet();
    test_credit_stall();
    test_same_cycle();
    test_ordy_err();
    test_random();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_local_injector.md
# noc_local_injector

Packet injector that drives a router's local input port (port 4) from a core-side streaming interface. It forms 35-bit flits: one head flit carrying destination and source coordinates, then one flit per payload word, with the last flit marked tail. It sends those flits with per-VC credit-based flow control driven by the router's OACK/ORDY returns. It sits between a tile's processing element and the router wrapper, in the same tile.

## Interface
Parameters:
- BUF_DEPTH, 4: router input buffer depth per VC; initial and maximum credit count.
- NUM_VC, 2: virtual channels; fixed at 2 by the router port widths.

Ports:
- clk  in  1  tile clock.
- RST_  in  1  reset. One clock; reset is asynchronous and active-low.
- MY_XPOS  in  2  this tile's X coordinate.
- MY_YPOS  in  2  this tile's Y coordinate.
- pkt_valid  in  1  core has a payload word or packet start.
- pkt_ready  out  1  payload word accepted this cycle.
- pkt_data  in  32  payload word.
- pkt_last  in  1  current word is the last of the packet.
- pkt_vc  in  1  VC for the packet; sampled at head only.
- pkt_dst_x  in  2  destination X; sampled at head only.
- pkt_dst_y  in  2  destination Y; sampled at head only.
- IDATA  out  35  flit to router IDATA_4.
- IVALID  out  1  flit valid to router IVALID_4.
- IVCH  out  1  flit VC to router IVCH_4.
- OACK  in  2  one-cycle credit-return pulse per VC, from router OACK_4.
- ORDY  in  2  router input ready per VC, from router ORDY_4.
- cred_err  out  1  sticky credit-overflow error.

## Operation
- Flit format: [34:33] type, where 00 = body, 01 = head, 10 = tail. [32:0] payload.
- Head payload: [7:6] dst_x, [5:4] dst_y, [3:2] MY_XPOS, [1:0] MY_YPOS. All other payload bits are 0.
- Body and tail payload: {1'b0, pkt_data}.
- A packet is one head flit plus at least one data flit. The head never consumes a core word.
- FSM has two states, IDLE and DATA.
- IDLE:
  - pkt_ready = 0.
  - If pkt_valid and can_send(pkt_vc): emit head, latch vc/dst, go to DATA.
- DATA:
  - pkt_ready = can_send(vc_latched).
  - On pkt_valid && pkt_ready: emit body, or tail if pkt_last. A tail returns the FSM to IDLE.
- can_send(v) = (credit[v] != 0) && ORDY[v].
- Credits:
  - One counter per VC, width $clog2(BUF_DEPTH+1).
  - Reset value is BUF_DEPTH.
  - Decrements by 1 when a flit is emitted on that VC.
  - Increments by 1 on OACK[v].
  - Emit and OACK on the same VC in the same cycle: net unchanged.
  - OACK with the counter at BUF_DEPTH: counter saturates and cred_err sets. cred_err clears only on reset.
- OACK on the non-active VC is always counted.
- Core must hold pkt_* stable while pkt_valid && !pkt_ready. This is not checked.

## Timing
- IDATA, IVALID and IVCH are registered. A flit appears in the cycle after the emit decision.
- IVALID is high for exactly one cycle per flit. Back-to-back flits are allowed, at one per cycle.
- Minimum packet: head then tail in two consecutive output cycles.
- Credit counters update at the clock edge of the emit decision. A zero credit stalls from the very next decision.
- Reset values:
  - IDATA = 0, IVALID = 0, IVCH = 0, pkt_ready = 0, cred_err = 0.
  - FSM = IDLE, credits = BUF_DEPTH.
- Reset asserted mid-packet: the partial packet is abandoned and no tail is emitted. Credits are restored to BUF_DEPTH; the router is reset on the same RST_.

## Configuration
- NOC_INJ_STATS_EN defined: adds outputs pkt_cnt[15:0] and stall_cnt[15:0].
  - pkt_cnt counts tails sent.
  - stall_cnt counts cycles where pkt_valid=1 and no flit is emitted.
  - Both are wrapping counters, reset to 0.
- NOC_INJ_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package noc_pkg holds:
  - FLIT_W = 35.
  - Flit type localparams FT_BODY, FT_HEAD, FT_TAIL.
  - Head field bit positions.
  - The injector FSM state enum.
  - The router wrapper and a future NI receiver reuse these definitions.
- Sub-module noc_credit_counter (parameter BUF_DEPTH; ports clk, RST_, dec, inc, cnt, nonzero, ovf). It is instantiated once per VC.

## Test plan
- Reset, then idle: all outputs are 0 and the credits read 4.
- pkt_vc=1, dst(2,3), MY(1,0), 3-word packet, ORDY=11: four flits on consecutive cycles. Head IDATA = {01, 33'h000000B4}, followed by body, body, tail; IVCH=1 on all four.
- BUF_DEPTH=4, no OACK, 6-word packet on VC0: the head and 3 data flits go out, then pkt_ready=0. Each OACK[0] pulse releases exactly one more flit.
- Credit for VC0 at 0, OACK[0] and a pending send in the same cycle: the flit goes out the next cycle and the credit returns to 0. Separately, emit and OACK on the same VC with credit 2: credit stays 2.
- ORDY[0]=0 with credits=4: no flit is emitted on VC0. An OACK[1] pulse at credit 4 sets cred_err, which stays set.
- RST_ pulsed low after the head and one body flit: the outputs clear asynchronously. A new packet then starts with a head flit and credits=4.
